// File: rtl/logic_pattern_seq.sv
// Stimulus sequencer: walks all N_IN-bit patterns with a valid/ready offer and a hold window.
// Define LOGIC_SEQ_CHECK_EN to add the operator-result checker (and/or/not inputs, sticky err).
module logic_pattern_seq #(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            ready,
`ifdef LOGIC_SEQ_CHECK_EN
  input  logic            and_in,
  input  logic            or_in,
  input  logic            not_a_in,
  input  logic            not_b_in,
  output logic            err,
  output logic [N_IN-1:0] err_idx,
`endif
  output logic [N_IN-1:0] pat_vec,
  output logic            pat_valid,
  output logic [N_IN-1:0] pat_idx,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [N_IN-1:0] LAST_PAT  = '1;
  localparam logic [7:0]      HOLD_INIT = 8'(HOLD_CYCLES);

  state_e            state_q;
  logic [N_IN-1:0]   vec_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        hold_q;
  logic              last_hold;

  assign last_hold = (state_q == HOLD) && (hold_q == 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRIVE;
            vec_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        DRIVE: begin
          if (ready) begin
            state_q <= HOLD;
            hold_q  <= HOLD_INIT;
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          // The hold window ends on the cycle where the counter reads 1.
          if (last_hold) begin
            hold_q <= '0;
            if (vec_q == LAST_PAT) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRIVE;
              vec_q   <= vec_q + 1'b1;
              valid_q <= 1'b1;
            end
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pat_vec   = vec_q;
  assign pat_idx   = vec_q;
  assign pat_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef LOGIC_SEQ_CHECK_EN
  logic            err_q;
  logic [N_IN-1:0] err_idx_q;
  logic            op_a;
  logic            op_b;
  logic            mismatch;

  assign op_a     = vec_q[1];
  assign op_b     = vec_q[0];
  assign mismatch = {and_in, or_in, not_a_in, not_b_in} !=
                    {op_a & op_b, op_a | op_b, ~op_a, ~op_b};

  // Only the first failing pattern is recorded; err stays set until reset or a new sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if (last_hold && mismatch && !err_q) begin
      err_q     <= 1'b1;
      err_idx_q <= vec_q;
    end
  end

  assign err     = err_q;
  assign err_idx = err_idx_q;
`endif

endmodule

// File: tb/tb_logic_pattern_seq.sv
// Directed bench for logic_pattern_seq (N_IN=2, HOLD_CYCLES=4): table-driven sweep plus corner sequences.
module tb_logic_pattern_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] pat_vec;
  logic [1:0] pat_idx;
  logic       pat_valid;
  logic       busy;
  logic       done;

`ifdef LOGIC_SEQ_CHECK_EN
  logic       bad_and = 1'b0;
  logic       and_in;
  logic       or_in;
  logic       not_a_in;
  logic       not_b_in;
  logic       err;
  logic [1:0] err_idx;

  // Reference operator block, with an optional stuck-at-0 AND on pattern 3.
  assign and_in   = pat_vec[1] & pat_vec[0] & ~(bad_and && (pat_vec == 2'd3));
  assign or_in    = pat_vec[1] | pat_vec[0];
  assign not_a_in = ~pat_vec[1];
  assign not_b_in = ~pat_vec[0];
`endif

  logic_pattern_seq #(.N_IN(2), .HOLD_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
`ifdef LOGIC_SEQ_CHECK_EN
    .and_in    (and_in),
    .or_in     (or_in),
    .not_a_in  (not_a_in),
    .not_b_in  (not_b_in),
    .err       (err),
    .err_idx   (err_idx),
`endif
    .pat_vec   (pat_vec),
    .pat_valid (pat_valid),
    .pat_idx   (pat_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       ready;
    logic [1:0] vec;
    logic       valid;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t       tbl [23];
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  logic [1:0] acc_q [$];

  function automatic vec_t mk(input int s, input int r, input int v,
                              input int va, input int b, input int d);
    vec_t t;
    t.start = s[0];
    t.ready = r[0];
    t.vec   = v[1:0];
    t.valid = va[0];
    t.busy  = b[0];
    t.done  = d[0];
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int v, input int va, input int b, input int d);
    chk({tag, ".vec"},   32'(pat_vec),   32'(v));
    chk({tag, ".idx"},   32'(pat_idx),   32'(v));
    chk({tag, ".valid"}, 32'(pat_valid), 32'(va));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".done"},  32'(done),      32'(d));
  endtask

  // One clock: log any handshake about to complete, advance, sample 1 ns after the edge.
  task automatic step();
    if (pat_valid && ready) acc_q.push_back(pat_vec);
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic start_sweep();
    acc_q.delete();
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      step();
      n++;
    end
    chk("done_reached", 32'(done), 32'd1);
    step();
  endtask

  task automatic check_sweep(input string tag);
    chk({tag, ".n_pat"}, 32'(acc_q.size()), 32'd4);
    for (int i = 0; i < acc_q.size() && i < 4; i++)
      chk({tag, ".order"}, 32'(acc_q[i]), 32'(i));
    chk({tag, ".n_done"}, 32'(done_cnt), 32'd1);
    check_outs({tag, ".after"}, 3, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Full sweep with ready high: pattern p offered after edge 5p, held for edges 5p+1..5p+4.
    tbl[0]  = mk(1, 1, 0, 1, 1, 0);
    tbl[1]  = mk(0, 1, 0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 0, 0, 1, 0);
    tbl[3]  = mk(0, 1, 0, 0, 1, 0);
    tbl[4]  = mk(0, 1, 0, 0, 1, 0);
    tbl[5]  = mk(0, 1, 1, 1, 1, 0);
    tbl[6]  = mk(0, 1, 1, 0, 1, 0);
    tbl[7]  = mk(0, 1, 1, 0, 1, 0);
    tbl[8]  = mk(0, 1, 1, 0, 1, 0);
    tbl[9]  = mk(0, 1, 1, 0, 1, 0);
    tbl[10] = mk(0, 1, 2, 1, 1, 0);
    tbl[11] = mk(0, 1, 2, 0, 1, 0);
    tbl[12] = mk(0, 1, 2, 0, 1, 0);
    tbl[13] = mk(0, 1, 2, 0, 1, 0);
    tbl[14] = mk(0, 1, 2, 0, 1, 0);
    tbl[15] = mk(0, 1, 3, 1, 1, 0);
    tbl[16] = mk(0, 1, 3, 0, 1, 0);
    tbl[17] = mk(0, 1, 3, 0, 1, 0);
    tbl[18] = mk(0, 1, 3, 0, 1, 0);
    tbl[19] = mk(0, 1, 3, 0, 1, 0);
    tbl[20] = mk(0, 1, 3, 0, 1, 1);
    tbl[21] = mk(0, 1, 3, 0, 0, 0);
    tbl[22] = mk(0, 1, 3, 0, 0, 0);

    // Reset held with start and ready high: everything stays cleared.
    start = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("reset%0d", i), 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    step();
    check_outs("post_reset", 0, 0, 0, 0);
    $display("reset sequence checked");

    // Table-driven full sweep.
    for (int i = 0; i < 23; i++) begin
      start = tbl[i].start;
      ready = tbl[i].ready;
      step();
      check_outs($sformatf("sweep[%0d]", i), int'(tbl[i].vec), int'(tbl[i].valid),
                 int'(tbl[i].busy), int'(tbl[i].done));
      $display("sweep edge %0d: vec=%0d valid=%0b busy=%0b done=%0b",
               i, pat_vec, pat_valid, busy, done);
    end

    // Backpressure on pattern 2.
    ready = 1'b1;
    start_sweep();
    repeat (10) step();
    check_outs("bp.offer", 2, 1, 1, 0);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs($sformatf("bp.stall%0d", i), 2, 1, 1, 0);
    end
    ready = 1'b1;
    step();
    check_outs("bp.accept", 2, 0, 1, 0);
    run_to_done(40);
    check_sweep("bp");
    $display("backpressure sweep: %0d patterns, %0d done pulses", acc_q.size(), done_cnt);

    // Start pulse during the hold of pattern 1 must not restart the sweep.
    start_sweep();
    repeat (6) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_outs("busy_start", 1, 0, 1, 0);
    run_to_done(40);
    check_sweep("busy_start");
    $display("start-while-busy sweep: %0d patterns, %0d done pulses", acc_q.size(), done_cnt);

    // Asynchronous reset during the hold of pattern 2, then a fresh sweep.
    start_sweep();
    repeat (11) step();
    check_outs("mid.hold", 2, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("mid.async", 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    check_outs("mid.idle", 0, 0, 0, 0);
    start_sweep();
    check_outs("mid.restart", 0, 1, 1, 0);
    run_to_done(40);
    check_sweep("mid");
    $display("post-reset sweep: %0d patterns, %0d done pulses", acc_q.size(), done_cnt);

`ifdef LOGIC_SEQ_CHECK_EN
    // Faulty AND on pattern 3, then a clean sweep that must clear err on start.
    bad_and = 1'b1;
    start_sweep();
    run_to_done(40);
    chk("chk_bad.err", 32'(err), 32'd1);
    chk("chk_bad.err_idx", 32'(err_idx), 32'd3);
    $display("checker faulty sweep: err=%0b err_idx=%0d", err, err_idx);
    bad_and = 1'b0;
    start_sweep();
    chk("chk_clear.err", 32'(err), 32'd0);
    run_to_done(40);
    chk("chk_good.err", 32'(err), 32'd0);
    $display("checker clean sweep: err=%0b", err);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
